// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the iterative restoring square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;

  function automatic int clog2_min1(input int n);
    int c;
    c = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) c = i + 1;
    end
    return (c < 1) ? 1 : c;
  endfunction

  function automatic bit legal_params(input int width, input int spc);
    bit ok;
    ok = (width % 2 == 0) && (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
    ok = ok && (spc == 1 || spc == 2);
    ok = ok && (spc != 0) && ((width / 2) % ((spc == 0) ? 1 : spc) == 0);
    return ok;
  endfunction

endpackage

// File: rtl/sqrt_restoring_multi_if.sv
// Request/response bundle of the square-root unit; slave side faces the datapath.
interface sqrt_restoring_multi_if #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
);
  localparam int QW    = WIDTH / 2;
  localparam int RW    = QW + 1;
  localparam int ITERS = QW / STEPS_PER_CYCLE;
  localparam int CW    = sqrt_pkg::clog2_min1(ITERS);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] d;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [QW-1:0]    q;
  logic [RW-1:0]    r;
  logic             busy;
  logic [CW-1:0]    count;

  modport slave (
    input  start_valid, d, cancel, out_ready,
    output start_ready, out_valid, q, r, busy, count
  );

  modport master (
    output start_valid, d, cancel, out_ready,
    input  start_ready, out_valid, q, r, busy, count
  );
endinterface

// File: rtl/sqrt_restoring_multi_step.sv
// One combinational restoring iteration: resolves a single root bit from two radicand bits.
module sqrt_restoring_step #(
  parameter int QW = 16
) (
  input  logic [QW-1:0] r_in,
  input  logic [QW-1:0] q_in,
  input  logic [1:0]    d2,
  output logic [QW:0]   r_out,
  output logic [QW-1:0] q_out
);
  localparam int RW = QW + 1;

  logic [RW:0] trial;

  always_comb begin
    trial = {r_in, d2} - {q_in, 2'b01};
    // A set MSB means the trial went negative: keep the shifted partial remainder.
    if (trial[RW]) begin
      r_out = {r_in[QW-2:0], d2};
      q_out = {q_in[QW-2:0], 1'b0};
    end else begin
      r_out = trial[RW-1:0];
      q_out = {q_in[QW-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/sqrt_restoring_multi.sv
// Iterative restoring integer square root, STEPS_PER_CYCLE root bits per clock,
// with valid/ready on both sides, cancel and a zero-radicand fast path.
module sqrt_restoring_multi
  import sqrt_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  sqrt_restoring_multi_if.slave  bus
);
  localparam int QW    = WIDTH / 2;
  localparam int RW    = QW + 1;
  localparam int ITERS = QW / STEPS_PER_CYCLE;
  localparam int CW    = clog2_min1(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  if (!legal_params(WIDTH, STEPS_PER_CYCLE)) begin : g_bad_params
    $error("sqrt_restoring_multi: illegal WIDTH/STEPS_PER_CYCLE combination");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic [QW-1:0]    q_q, q_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CW-1:0]    count_q, count_d;

  logic [QW-1:0] q_ch [0:STEPS_PER_CYCLE];
  logic [RW-1:0] r_ch [0:STEPS_PER_CYCLE];

  assign q_ch[0] = q_q;
  assign r_ch[0] = r_q;

  for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
    sqrt_restoring_step #(.QW(QW)) u_step (
      .r_in  (r_ch[k][QW-1:0]),
      .q_in  (q_ch[k]),
      .d2    (dreg_q[WIDTH-1-2*k -: 2]),
      .r_out (r_ch[k+1]),
      .q_out (q_ch[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    dreg_d  = dreg_q;
    q_d     = q_q;
    r_d     = r_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid && !bus.cancel) begin
          dreg_d  = bus.d;
          q_d     = '0;
          r_d     = '0;
          count_d = '0;
          state_d = (bus.d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          q_d     = q_ch[STEPS_PER_CYCLE];
          r_d     = r_ch[STEPS_PER_CYCLE];
          dreg_d  = dreg_q << (2 * STEPS_PER_CYCLE);
          count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
          if (count_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.cancel || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dreg_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dreg_q  <= dreg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      count_q <= count_d;
    end
  end

  // Handshake flags decode registered state only; cancel just blocks a new accept.
  assign bus.start_ready = (state_q == IDLE) && !bus.cancel;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.count       = count_q;
endmodule

// File: doc/sqrt_restoring_multi.md
Name: sqrt_restoring_multi

Overview:
- Parametrised iterative restoring integer square root for the ALU extract-root library; next generation of the fixed 32/16-bit unit.
- Computes floor root and remainder of an unsigned WIDTH-bit radicand.
- Resolves STEPS_PER_CYCLE root bits per clock.
- Adds a valid/ready handshake on both sides, result hold under back-pressure, cancel, and a zero-radicand fast path.

Parameters:
- WIDTH, 32, radicand width; even, 4..64.
- STEPS_PER_CYCLE, 1, root bits resolved per cycle; 1 or 2; must divide WIDTH/2.
- Localparams (not overridable):
  - QW = WIDTH/2
  - RW = QW+1
  - ITERS = QW/STEPS_PER_CYCLE
  - CW = max(1, clog2(ITERS))

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start_valid  in  1  request carries a radicand.
- start_ready  out  1  block accepts a request this cycle.
- d  in  WIDTH  unsigned radicand; sampled on start handshake only.
- cancel  in  1  abort the current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- q  out  QW  root.
- r  out  RW  remainder; r = d - q*q.
- busy  out  1  high in RUN or DONE.
- count  out  CW  iteration counter; simulation visibility only.

Behaviour:
- Reset is sampled on the clock edge and overrides all other inputs. It forces:
  - state IDLE; start_ready=1; out_valid=0; busy=0
  - q=0; r=0; count=0; internal radicand register 0
  - reset asserted mid-RUN or mid-DONE discards the operation; no out_valid follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = ~cancel.
  - Handshake = start_valid & start_ready. On handshake, load d into the shift register and clear q, r and count.
  - If d==0: go directly to DONE (q=0, r=0); out_valid rises one cycle after accept.
  - Otherwise go to RUN.
- RUN, each cycle performs STEPS_PER_CYCLE chained iterations. One iteration:
  - trial = {r[QW-1:0], dreg[WIDTH-1:WIDTH-2]} - {q, 2'b01}, computed (RW+1) bits wide.
  - If trial MSB=1 (negative): new_r = {r[QW-2:0], dreg top 2 bits}; q bit = 0.
  - Else: new_r = trial[RW-1:0]; q bit = 1.
  - q shifts left one bit, taking the new q bit as LSB. dreg shifts left by 2, zero-filled.
  - count increments once per cycle. When count == ITERS-1, go to DONE; count wraps to 0.
- Latency: accept at edge N gives out_valid high after edge N+ITERS. WIDTH=32 gives 16 cycles with STEPS_PER_CYCLE=1 and 8 cycles with STEPS_PER_CYCLE=2.
- DONE:
  - out_valid=1; q and r held stable while out_ready=0, for any number of cycles.
  - out_valid & out_ready returns to IDLE next cycle.
  - The next start is accepted no earlier than the cycle after the output handshake; no overlap.
- cancel:
  - In RUN or DONE: go to IDLE next cycle; out_valid deasserts; q and r hold last values but are meaningless.
  - In DONE with out_ready also high in the same cycle: the output handshake completes (result consumed); the next state is IDLE either way.
  - In IDLE: no start is accepted that cycle; otherwise ignored.
- start_valid while busy is ignored; no queueing.
- start_ready, out_valid and busy are registered-state decodes only. start_ready additionally gates with cancel. No output depends combinationally on out_ready.

Decomposition:
- Package sqrt_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - function clog2_min1
  - parameter-legality check constants; elaboration error if WIDTH is odd, or if STEPS_PER_CYCLE is not 1 or 2, or does not divide QW.
- Sub-module sqrt_restoring_step: one purely combinational iteration.
  - Inputs: r_in, q_in, two radicand bits.
  - Outputs: r_out, q_out.
  - Parametrised by QW; instantiated STEPS_PER_CYCLE times in a chain.

Test Plan:
- WIDTH=32, S=1, d=0xFFFFFFFF -> q=0xFFFF, r=0x1FFFE; out_valid exactly 16 cycles after accept; d=1000000 -> q=1000, r=0; d=99 -> q=9, r=18.
- d=0 -> out_valid one cycle after accept, q=0, r=0; then d=1 -> q=1, r=0 after 16 cycles.
- Back-pressure: out_ready held low 10 cycles with d=50 -> q=7, r=1 stable throughout. start_valid pulses during that time are not accepted (start_ready=0).
- Cancel at cycle 5 of RUN with d=0x12345678 -> IDLE next cycle, no out_valid. Following d=16 -> q=4, r=0, full 16-cycle latency.
- Synchronous reset mid-RUN -> all outputs zero on the next edge, no stale out_valid. Reset with start_valid=1 on the same edge -> no start accepted.
- WIDTH=8, S=2, exhaustive d=0..255 with random out_ready -> q=floor(sqrt(d)), r=d-q*q, 2-cycle latency each, scoreboard against a model.
